rs_alu: RTL and testbench

- Reservation station for the ALU/branch path of the Tomasulo core.
- Sits between dispatch and the execute unit. It buffers decoded instructions and snoops the two result buses (execute and SLB) to capture pending operands.
- Each cycle it issues at most one fully-ready entry to execute, as a registered single-cycle pulse.

---
 rtl/rs_alu.sv | 229 ++++++++++++++++++++++
 tb/tb_rs_alu.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_alu.sv
`default_nettype none
// ============================================================================
// Module      : rs_alu
// Description : ALU/branch reservation station. Buffers dispatched
//               instructions, snoops the EX and SLB result buses, and issues
//               the lowest-index fully-ready slot as a registered pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module rs_alu #(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = 4,
    parameter int NICK_W  = 4,
    parameter int OP_W    = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              iDP_en,
    input  logic [31:0]       iDP_pc,
    input  logic [OP_W-1:0]   iDP_op,
    input  logic [31:0]       iDP_imm,
    input  logic [NICK_W-1:0] iDP_rd_nick,
    input  logic              iDP_rs1_rdy,
    input  logic [31:0]       iDP_rs1_dt,
    input  logic [NICK_W-1:0] iDP_rs1_nick,
    input  logic              iDP_rs2_rdy,
    input  logic [31:0]       iDP_rs2_dt,
    input  logic [NICK_W-1:0] iDP_rs2_nick,
    input  logic              iEX_en,
    input  logic [NICK_W-1:0] iEX_nick,
    input  logic [31:0]       iEX_dt,
    input  logic              iSLB_en,
    input  logic [NICK_W-1:0] iSLB_nick,
    input  logic [31:0]       iSLB_dt,
    output logic              oRS_full,
    output logic              oRS_en,
    output logic [31:0]       oRS_pc,
    output logic [OP_W-1:0]   oRS_op,
    output logic [31:0]       oRS_imm,
    output logic [NICK_W-1:0] oRS_rd_nick,
    output logic [31:0]       oRS_rs1_dt,
    output logic [31:0]       oRS_rs2_dt
);

    // Slot storage
    logic [ENTRIES-1:0] busy_q,    busy_d;
    logic [ENTRIES-1:0] rs1_rdy_q, rs1_rdy_d;
    logic [ENTRIES-1:0] rs2_rdy_q, rs2_rdy_d;
    logic [31:0]        pc_q      [ENTRIES];
    logic [31:0]        pc_d      [ENTRIES];
    logic [OP_W-1:0]    op_q      [ENTRIES];
    logic [OP_W-1:0]    op_d      [ENTRIES];
    logic [31:0]        imm_q     [ENTRIES];
    logic [31:0]        imm_d     [ENTRIES];
    logic [NICK_W-1:0]  rd_q      [ENTRIES];
    logic [NICK_W-1:0]  rd_d      [ENTRIES];
    logic [31:0]        rs1_dt_q  [ENTRIES];
    logic [31:0]        rs1_dt_d  [ENTRIES];
    logic [NICK_W-1:0]  rs1_nick_q[ENTRIES];
    logic [NICK_W-1:0]  rs1_nick_d[ENTRIES];
    logic [31:0]        rs2_dt_q  [ENTRIES];
    logic [31:0]        rs2_dt_d  [ENTRIES];
    logic [NICK_W-1:0]  rs2_nick_q[ENTRIES];
    logic [NICK_W-1:0]  rs2_nick_d[ENTRIES];

    // Issue output registers
    logic              en_q,     en_d;
    logic [31:0]       o_pc_q,   o_pc_d;
    logic [OP_W-1:0]   o_op_q,   o_op_d;
    logic [31:0]       o_imm_q,  o_imm_d;
    logic [NICK_W-1:0] o_rd_q,   o_rd_d;
    logic [31:0]       o_rs1_q,  o_rs1_d;
    logic [31:0]       o_rs2_q,  o_rs2_d;

    logic [ENTRIES-1:0] w_cand;
    logic [IDX_W-1:0]   w_free_idx;
    logic [IDX_W-1:0]   w_iss_idx;
    logic               w_iss_any;
    logic               w_dp_ok;
    logic               w_rs1_ex_hit, w_rs1_slb_hit;
    logic               w_rs2_ex_hit, w_rs2_slb_hit;

    genvar g;
    generate
        for (g = 0; g < ENTRIES; g++) begin : g_cand
            assign w_cand[g] = busy_q[g] & rs1_rdy_q[g] & rs2_rdy_q[g];
        end
    endgenerate

    // Lowest-index priority encoders for the free slot and the issue slot
    always_comb begin
        w_free_idx = '0;
        w_iss_idx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!busy_q[i]) w_free_idx = IDX_W'(i);
            if (w_cand[i])  w_iss_idx  = IDX_W'(i);
        end
    end

    assign w_iss_any     = |w_cand;
    assign oRS_full      = &busy_q;
    assign w_dp_ok       = iDP_en & ~oRS_full;
    assign w_rs1_ex_hit  = iEX_en  && (iEX_nick  == iDP_rs1_nick);
    assign w_rs1_slb_hit = iSLB_en && (iSLB_nick == iDP_rs1_nick);
    assign w_rs2_ex_hit  = iEX_en  && (iEX_nick  == iDP_rs2_nick);
    assign w_rs2_slb_hit = iSLB_en && (iSLB_nick == iDP_rs2_nick);

    always_comb begin
        busy_d     = busy_q;
        rs1_rdy_d  = rs1_rdy_q;
        rs2_rdy_d  = rs2_rdy_q;
        pc_d       = pc_q;
        op_d       = op_q;
        imm_d      = imm_q;
        rd_d       = rd_q;
        rs1_dt_d   = rs1_dt_q;
        rs1_nick_d = rs1_nick_q;
        rs2_dt_d   = rs2_dt_q;
        rs2_nick_d = rs2_nick_q;
        en_d       = 1'b0;
        o_pc_d     = o_pc_q;
        o_op_d     = o_op_q;
        o_imm_d    = o_imm_q;
        o_rd_d     = o_rd_q;
        o_rs1_d    = o_rs1_q;
        o_rs2_d    = o_rs2_q;

        if (clr) begin
            busy_d = '0;
        end else begin
            // Wakeup; EX takes precedence if both buses carry the same tag
            for (int i = 0; i < ENTRIES; i++) begin
                if (busy_q[i] && !rs1_rdy_q[i]) begin
                    if (iEX_en && iEX_nick == rs1_nick_q[i]) begin
                        rs1_rdy_d[i] = 1'b1;
                        rs1_dt_d[i]  = iEX_dt;
                    end else if (iSLB_en && iSLB_nick == rs1_nick_q[i]) begin
                        rs1_rdy_d[i] = 1'b1;
                        rs1_dt_d[i]  = iSLB_dt;
                    end
                end
                if (busy_q[i] && !rs2_rdy_q[i]) begin
                    if (iEX_en && iEX_nick == rs2_nick_q[i]) begin
                        rs2_rdy_d[i] = 1'b1;
                        rs2_dt_d[i]  = iEX_dt;
                    end else if (iSLB_en && iSLB_nick == rs2_nick_q[i]) begin
                        rs2_rdy_d[i] = 1'b1;
                        rs2_dt_d[i]  = iSLB_dt;
                    end
                end
            end

            if (w_iss_any) begin
                en_d              = 1'b1;
                o_pc_d            = pc_q[w_iss_idx];
                o_op_d            = op_q[w_iss_idx];
                o_imm_d           = imm_q[w_iss_idx];
                o_rd_d            = rd_q[w_iss_idx];
                o_rs1_d           = rs1_dt_q[w_iss_idx];
                o_rs2_d           = rs2_dt_q[w_iss_idx];
                busy_d[w_iss_idx] = 1'b0;
            end

            // The free slot is never the issuing slot, so freed slots wait a cycle
            if (w_dp_ok) begin
                busy_d[w_free_idx]     = 1'b1;
                pc_d[w_free_idx]       = iDP_pc;
                op_d[w_free_idx]       = iDP_op;
                imm_d[w_free_idx]      = iDP_imm;
                rd_d[w_free_idx]       = iDP_rd_nick;
                rs1_nick_d[w_free_idx] = iDP_rs1_nick;
                rs2_nick_d[w_free_idx] = iDP_rs2_nick;
                rs1_rdy_d[w_free_idx]  = iDP_rs1_rdy | w_rs1_ex_hit | w_rs1_slb_hit;
                rs2_rdy_d[w_free_idx]  = iDP_rs2_rdy | w_rs2_ex_hit | w_rs2_slb_hit;
                rs1_dt_d[w_free_idx]   = iDP_rs1_rdy  ? iDP_rs1_dt :
                                         w_rs1_ex_hit ? iEX_dt     :
                                         w_rs1_slb_hit ? iSLB_dt   : iDP_rs1_dt;
                rs2_dt_d[w_free_idx]   = iDP_rs2_rdy  ? iDP_rs2_dt :
                                         w_rs2_ex_hit ? iEX_dt     :
                                         w_rs2_slb_hit ? iSLB_dt   : iDP_rs2_dt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            en_q      <= 1'b0;
            o_pc_q    <= '0;
            o_op_q    <= '0;
            o_imm_q   <= '0;
            o_rd_q    <= '0;
            o_rs1_q   <= '0;
            o_rs2_q   <= '0;
        end else if (rdy) begin
            busy_q     <= busy_d;
            rs1_rdy_q  <= rs1_rdy_d;
            rs2_rdy_q  <= rs2_rdy_d;
            pc_q       <= pc_d;
            op_q       <= op_d;
            imm_q      <= imm_d;
            rd_q       <= rd_d;
            rs1_dt_q   <= rs1_dt_d;
            rs1_nick_q <= rs1_nick_d;
            rs2_dt_q   <= rs2_dt_d;
            rs2_nick_q <= rs2_nick_d;
            en_q       <= en_d;
            o_pc_q     <= o_pc_d;
            o_op_q     <= o_op_d;
            o_imm_q    <= o_imm_d;
            o_rd_q     <= o_rd_d;
            o_rs1_q    <= o_rs1_d;
            o_rs2_q    <= o_rs2_d;
        end
    end

    assign oRS_en      = en_q;
    assign oRS_pc      = o_pc_q;
    assign oRS_op      = o_op_q;
    assign oRS_imm     = o_imm_q;
    assign oRS_rd_nick = o_rd_q;
    assign oRS_rs1_dt  = o_rs1_q;
    assign oRS_rs2_dt  = o_rs2_q;

endmodule
`default_nettype wire

// File: tb/tb_rs_alu.sv
`default_nettype none
// ============================================================================
// Module      : tb_rs_alu
// Description : Self-checking bench for rs_alu: directed scenarios plus random
//               traffic, scored against a slot-list reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rs_alu;

    logic        clk = 1'b0;
    logic        rst, rdy, clr;
    logic        iDP_en;
    logic [31:0] iDP_pc, iDP_imm, iDP_rs1_dt, iDP_rs2_dt;
    logic [5:0]  iDP_op;
    logic [3:0]  iDP_rd_nick, iDP_rs1_nick, iDP_rs2_nick;
    logic        iDP_rs1_rdy, iDP_rs2_rdy;
    logic        iEX_en, iSLB_en;
    logic [3:0]  iEX_nick, iSLB_nick;
    logic [31:0] iEX_dt, iSLB_dt;
    logic        oRS_full, oRS_en;
    logic [31:0] oRS_pc, oRS_imm, oRS_rs1_dt, oRS_rs2_dt;
    logic [5:0]  oRS_op;
    logic [3:0]  oRS_rd_nick;

    always #5 clk = ~clk;

    rs_alu #(.ENTRIES(16), .IDX_W(4), .NICK_W(4), .OP_W(6)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .iDP_en(iDP_en), .iDP_pc(iDP_pc), .iDP_op(iDP_op), .iDP_imm(iDP_imm),
        .iDP_rd_nick(iDP_rd_nick),
        .iDP_rs1_rdy(iDP_rs1_rdy), .iDP_rs1_dt(iDP_rs1_dt), .iDP_rs1_nick(iDP_rs1_nick),
        .iDP_rs2_rdy(iDP_rs2_rdy), .iDP_rs2_dt(iDP_rs2_dt), .iDP_rs2_nick(iDP_rs2_nick),
        .iEX_en(iEX_en), .iEX_nick(iEX_nick), .iEX_dt(iEX_dt),
        .iSLB_en(iSLB_en), .iSLB_nick(iSLB_nick), .iSLB_dt(iSLB_dt),
        .oRS_full(oRS_full), .oRS_en(oRS_en), .oRS_pc(oRS_pc), .oRS_op(oRS_op),
        .oRS_imm(oRS_imm), .oRS_rd_nick(oRS_rd_nick),
        .oRS_rs1_dt(oRS_rs1_dt), .oRS_rs2_dt(oRS_rs2_dt)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [31:0] imm;
        logic [3:0]  rd;
        logic [31:0] d1;
        logic [31:0] d2;
    } issue_t;

    typedef struct {
        bit          busy;
        issue_t      f;
        bit          r1, r2;
        logic [3:0]  n1, n2;
    } slot_t;

    slot_t  m[16];
    issue_t exp_q[$];
    issue_t m_last = '0;
    bit     m_en = 1'b0;
    bit     live = 1'b0;
    bit     started = 1'b0;
    int     checks = 0;
    int     failures = 0;
    int     n_issued = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic bit bus_hit(input logic [3:0] n, output logic [31:0] v);
        v = '0;
        if (iEX_en && iEX_nick == n) begin v = iEX_dt; return 1'b1; end
        if (iSLB_en && iSLB_nick == n) begin v = iSLB_dt; return 1'b1; end
        return 1'b0;
    endfunction

    // Reference model: a list of slots; issue the first ready one, fill the first empty one
    always @(posedge clk) begin
        int fr, pk;
        logic [31:0] v;
        started = 1'b1;
        if (rst) begin
            foreach (m[i]) m[i].busy = 1'b0;
            m_en = 1'b0; m_last = '0; live = 1'b0;
        end else if (!rdy) begin
            live = 1'b0;
        end else begin
            live = 1'b1;
            if (clr) begin
                foreach (m[i]) m[i].busy = 1'b0;
                m_en = 1'b0;
            end else begin
                fr = -1; pk = -1;
                for (int i = 0; i < 16; i++) if (!m[i].busy && fr < 0) fr = i;
                for (int i = 0; i < 16; i++) if (m[i].busy && m[i].r1 && m[i].r2 && pk < 0) pk = i;
                if (pk >= 0) begin
                    exp_q.push_back(m[pk].f);
                    m_last = m[pk].f;
                    m[pk].busy = 1'b0;
                    m_en = 1'b1;
                end else begin
                    m_en = 1'b0;
                end
                for (int i = 0; i < 16; i++) begin
                    if (m[i].busy && !m[i].r1 && bus_hit(m[i].n1, v)) begin m[i].r1 = 1; m[i].f.d1 = v; end
                    if (m[i].busy && !m[i].r2 && bus_hit(m[i].n2, v)) begin m[i].r2 = 1; m[i].f.d2 = v; end
                end
                if (iDP_en && fr >= 0) begin
                    m[fr].busy = 1'b1;
                    m[fr].f = '{pc: iDP_pc, op: iDP_op, imm: iDP_imm, rd: iDP_rd_nick,
                                d1: iDP_rs1_dt, d2: iDP_rs2_dt};
                    m[fr].n1 = iDP_rs1_nick; m[fr].n2 = iDP_rs2_nick;
                    m[fr].r1 = iDP_rs1_rdy;  m[fr].r2 = iDP_rs2_rdy;
                    if (!iDP_rs1_rdy && bus_hit(iDP_rs1_nick, v)) begin m[fr].r1 = 1; m[fr].f.d1 = v; end
                    if (!iDP_rs2_rdy && bus_hit(iDP_rs2_nick, v)) begin m[fr].r2 = 1; m[fr].f.d2 = v; end
                end
            end
        end
    end

    // Monitor: compares what the DUT presents against the model and the scoreboard queue
    always @(negedge clk) begin
        bit     full_exp;
        issue_t act, e;
        if (started) begin
            full_exp = 1'b1;
            foreach (m[i]) if (!m[i].busy) full_exp = 1'b0;
            act = '{pc: oRS_pc, op: oRS_op, imm: oRS_imm, rd: oRS_rd_nick,
                    d1: oRS_rs1_dt, d2: oRS_rs2_dt};
            chk("full", 160'(oRS_full), 160'(full_exp));
            chk("en", 160'(oRS_en), 160'(m_en));
            chk("data_regs", 160'(act), 160'(m_last));
            if (live && oRS_en) begin
                n_issued++;
                if (exp_q.size() == 0) begin
                    chk("unexpected_issue", 160'(act), 160'(0) - 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("issue", 160'(act), 160'(e));
                end
            end
            chk("missed_issue", 160'(exp_q.size()), 160'(0));
            exp_q.delete();
        end
    end

    task automatic idle();
        rdy = 1'b1; clr = 1'b0; iDP_en = 1'b0; iEX_en = 1'b0; iSLB_en = 1'b0;
    endtask

    task automatic dp(input logic [31:0] pc, input logic [3:0] rd,
                      input logic r1, input logic [31:0] d1, input logic [3:0] n1,
                      input logic r2, input logic [31:0] d2, input logic [3:0] n2);
        iDP_en = 1'b1; iDP_pc = pc; iDP_op = 6'(pc); iDP_imm = ~pc; iDP_rd_nick = rd;
        iDP_rs1_rdy = r1; iDP_rs1_dt = d1; iDP_rs1_nick = n1;
        iDP_rs2_rdy = r2; iDP_rs2_dt = d2; iDP_rs2_nick = n2;
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int base;
        rst = 1'b1; idle();
        iDP_pc = '0; iDP_op = '0; iDP_imm = '0; iDP_rd_nick = '0;
        iDP_rs1_rdy = 0; iDP_rs1_dt = '0; iDP_rs1_nick = '0;
        iDP_rs2_rdy = 0; iDP_rs2_dt = '0; iDP_rs2_nick = '0;
        iEX_nick = '0; iEX_dt = '0; iSLB_nick = '0; iSLB_dt = '0;
        cyc(3);
        chk("reset_outputs", {oRS_en, oRS_full, oRS_pc, oRS_op, oRS_imm, oRS_rd_nick, oRS_rs1_dt, oRS_rs2_dt}, '0);
        rst = 1'b0;

        // Fully ready dispatch: two edges to issue
        dp(32'h100, 4'd3, 1, 32'd5, 4'd0, 1, 32'd7, 4'd0); cyc(); idle();
        chk("t1_not_early", 160'(oRS_en), 160'(0));
        cyc();
        chk("t1_en", 160'(oRS_en), 160'(1));
        chk("t1_fields", {oRS_pc, oRS_rs1_dt, oRS_rs2_dt, oRS_rd_nick}, {32'h100, 32'd5, 32'd7, 4'd3});
        cyc();
        chk("t1_pulse", 160'(oRS_en), 160'(0));

        // Wakeup via EX
        dp(32'h200, 4'd4, 0, 32'd0, 4'd2, 1, 32'd1, 4'd0); cyc(); idle(); cyc();
        chk("t2_wait", 160'(oRS_en), 160'(0));
        iEX_en = 1; iEX_nick = 4'd2; iEX_dt = 32'hDEAD; cyc(); idle();
        chk("t2_not_same_cycle", 160'(oRS_en), 160'(0));
        cyc();
        chk("t2_issue", {oRS_en, oRS_rs1_dt}, {1'b1, 32'hDEAD});

        // Dispatch-time bypass from SLB
        dp(32'h300, 4'd5, 0, 32'd0, 4'd6, 1, 32'd2, 4'd0);
        iSLB_en = 1; iSLB_nick = 4'd6; iSLB_dt = 32'h42; cyc(); idle(); cyc();
        chk("t3_bypass", {oRS_en, oRS_rs1_dt}, {1'b1, 32'h42});
        cyc(2);

        // Fill all slots, overflow dispatch ignored, then drain in slot order
        for (int i = 0; i < 16; i++) begin
            dp(32'h1000 + i, 4'(i), 0, 32'd0, 4'd9, 1, 32'(i), 4'd0); cyc();
        end
        idle();
        chk("t4_full", 160'(oRS_full), 160'(1));
        dp(32'hBAD, 4'd1, 1, 32'd1, 4'd0, 1, 32'd1, 4'd0); cyc(); idle();
        chk("t4_still_full", 160'(oRS_full), 160'(1));
        iEX_en = 1; iEX_nick = 4'd9; iEX_dt = 32'h99; cyc(); idle();
        base = n_issued;
        cyc();
        chk("t4_first", {oRS_en, oRS_pc, oRS_full}, {1'b1, 32'h1000, 1'b0});
        cyc(16);
        chk("t4_count", 160'(n_issued - base), 160'(16));

        // Flush with ready and waiting entries
        for (int i = 0; i < 3; i++) begin dp(32'h500 + i, 4'(i), 1, 32'd1, 4'd0, 1, 32'd2, 4'd0); cyc(); end
        dp(32'h510, 4'd7, 0, 32'd0, 4'd11, 1, 32'd3, 4'd0); cyc();
        dp(32'h520, 4'd8, 1, 32'd4, 4'd0, 1, 32'd5, 4'd0);
        clr = 1; iEX_en = 1; iEX_nick = 4'd11; iEX_dt = 32'h11; cyc(); idle();
        chk("t5_flush", {oRS_en, oRS_full}, 2'b00);
        base = n_issued;
        iEX_en = 1; iEX_nick = 4'd11; cyc(); idle(); cyc(3);
        chk("t5_no_issue", 160'(n_issued - base), 160'(0));

        // Stall with rdy low
        dp(32'h600, 4'd9, 0, 32'd0, 4'd12, 1, 32'd6, 4'd0); cyc();
        dp(32'h610, 4'd10, 1, 32'd7, 4'd0, 1, 32'd8, 4'd0); cyc(); idle();
        base = n_issued;
        rdy = 0; iEX_en = 1; iEX_nick = 4'd12; iEX_dt = 32'h12;
        dp(32'h620, 4'd11, 1, 32'd9, 4'd0, 1, 32'd9, 4'd0); cyc(3);
        chk("t6_stalled", 160'(n_issued - base), 160'(0));
        idle(); cyc();
        chk("t6_resume", {oRS_en, oRS_pc}, {1'b1, 32'h610});
        iEX_en = 1; iEX_nick = 4'd12; iEX_dt = 32'h12; cyc(); idle(); cyc(3);

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            idle();
            rdy = ($urandom_range(9) != 0);
            clr = ($urandom_range(39) == 0);
            if ($urandom_range(9) < 6)
                dp($urandom, 4'($urandom), 1'($urandom), $urandom, 4'($urandom),
                   1'($urandom), $urandom, 4'($urandom));
            iEX_en = 1'($urandom); iEX_nick = 4'($urandom); iEX_dt = $urandom;
            iSLB_en = 1'($urandom); iSLB_nick = 4'($urandom); iSLB_dt = $urandom;
            if (iEX_en && iSLB_en && iEX_nick == iSLB_nick) iSLB_nick = iEX_nick + 4'd1;
            cyc();
        end

        // Drain by broadcasting every tag
        idle();
        for (int t = 0; t < 16; t++) begin
            iEX_en = 1; iEX_nick = 4'(t); iEX_dt = 32'(t); cyc();
        end
        idle(); cyc(20);
        chk("drained", 160'(oRS_full), 160'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
